// File: rtl/uart_frame_tx_pkg.sv
// Shared constants and types for the LED frame UART link (transmit and receive sides).
package uart_frame_tx_pkg;

  localparam logic [7:0] FRAME_HDR = 8'h41;
  localparam int         FRAME_LEN = 16;
  localparam int         IDX_W     = $clog2(FRAME_LEN);

  // Bit period in clock cycles; truncating division so both sides agree exactly.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_HDR  = 2'd1,
    SEND_DATA = 2'd2,
    FINISH    = 2'd3
  } frame_state_e;

endpackage

// File: rtl/uart_frame_tx_if.sv
// Host-side bus of the frame transmitter: buffer writes, start request, serial line and status.
interface uart_frame_tx_if;
  logic       i_wr_en;
  logic [3:0] i_wr_addr;
  logic [7:0] i_wr_data;
  logic       i_start;
  logic       TX;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_start,
    input  TX, o_busy, o_done
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_start,
    output TX, o_busy, o_done
  );
endinterface

// File: rtl/uart_frame_tx_txuart.sv
// Single-byte 8N1 serializer: accepts a byte when idle, shifts it out LSB first.
module txuart #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       TX
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          busy_q;
  logic          tx_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else if (!busy_q) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      if (i_valid) begin
        busy_q <= 1'b1;
        tx_q   <= 1'b0;
        shreg  <= {1'b1, i_data, 1'b0};
      end
    end else if (baud_cnt == CW'(CLKS_PER_BIT - 1)) begin
      baud_cnt <= '0;
      // bit 9 is the stop bit: line is already high, just release
      if (bit_cnt == 4'd9) begin
        busy_q <= 1'b0;
        tx_q   <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        shreg   <= {1'b1, shreg[9:1]};
        tx_q    <= shreg[1];
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign o_busy = busy_q;
  assign TX     = tx_q;

endmodule

// File: rtl/uart_frame_tx.sv
// LED frame transmitter: 16-byte column buffer sent as header 'A' plus 16 bytes over 8N1 UART.
module uart_frame_tx
  import uart_frame_tx_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115200
) (
  input  logic          CLK,
  input  logic          RST,
  uart_frame_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  frame_state_e            state, state_d;
  logic [IDX_W-1:0]        idx, idx_d;
  logic                    sent, sent_d;
  logic                    start_q;
  logic                    busy;
  logic                    tx_valid;
  logic [7:0]              tx_data;
  logic                    tx_busy;
  logic                    tx_line;
  logic [FRAME_LEN-1:0][7:0] fbuf;

  assign busy = (state != IDLE);

  // Buffer has no reset: contents survive RST and rely on power-up zero of the registers.
  always_ff @(posedge CLK) begin
    if (!RST && bus.i_wr_en && !busy)
      fbuf[bus.i_wr_addr] <= bus.i_wr_data;
  end

  // Start is registered only while idle, so requests during a frame are dropped, not queued.
  always_ff @(posedge CLK) begin
    if (RST) start_q <= 1'b0;
    else     start_q <= bus.i_start && (state == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
      sent  <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      sent  <= sent_d;
    end
  end

  // 'sent' marks the current byte as handed to the serializer; completion is its busy falling.
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    sent_d   = sent;
    tx_valid = 1'b0;
    tx_data  = FRAME_HDR;
    case (state)
      IDLE: begin
        idx_d  = '0;
        sent_d = 1'b0;
        if (start_q) state_d = SEND_HDR;
      end
      SEND_HDR: begin
        tx_data = FRAME_HDR;
        if (!sent) begin
          tx_valid = 1'b1;
          if (!tx_busy) sent_d = 1'b1;
        end else if (!tx_busy) begin
          sent_d  = 1'b0;
          state_d = SEND_DATA;
        end
      end
      SEND_DATA: begin
        tx_data = fbuf[idx];
        if (!sent) begin
          tx_valid = 1'b1;
          if (!tx_busy) sent_d = 1'b1;
        end else if (!tx_busy) begin
          sent_d = 1'b0;
          if (idx == IDX_W'(FRAME_LEN - 1)) state_d = FINISH;
          else                              idx_d   = idx + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  txuart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_txuart (
    .CLK     (CLK),
    .RST     (RST),
    .i_valid (tx_valid),
    .i_data  (tx_data),
    .o_busy  (tx_busy),
    .TX      (tx_line)
  );

  assign bus.TX     = tx_line;
  assign bus.o_busy = busy;
  assign bus.o_done = (state == FINISH);

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: UART line decoder plus buffer model, randomized frame contents.
module tb_uart_frame_tx;

  localparam int CLK_HZ   = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_HZ / BAUD;
  localparam int BYTE_T   = 10 * CPB;
  localparam int FT       = 17 * (BYTE_T + 2) + 4;
  localparam int BUSY_MAX = 17 * BYTE_T + 34 + 3;

  typedef logic [0:16][7:0] frame_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_frame_tx_if bus();

  uart_frame_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [16];
  logic [7:0] rxq [$];
  int         stq [$];
  int         dq  [$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         busy_cnt = 0;
  int         frame_err = 0;

  // Line decoder: find falling edge, sample mid-bit, expect 0 start and 1 stop.
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh;
  logic       prev_tx = 1'b1;

  always @(negedge CLK) begin
    cyc++;
    if (bus.o_done === 1'b1) begin
      done_cnt++;
      dq.push_back(cyc);
    end
    if (bus.o_busy === 1'b1) busy_cnt++;
    if (RST) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (prev_tx === 1'b1 && bus.TX === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
        stq.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        int k;
        k = rx_cnt / CPB;
        if (k == 0) begin
          if (bus.TX !== 1'b0) frame_err++;
        end else if (k <= 8) begin
          rx_sh[k-1] = bus.TX;
        end else begin
          if (bus.TX !== 1'b1) frame_err++;
          rxq.push_back(rx_sh);
          rx_act = 1'b0;
        end
      end
    end
    prev_tx = bus.TX;
  end

  function automatic frame_t exp_frame();
    frame_t f;
    f[0] = 8'h41;
    for (int i = 0; i < 16; i++) f[i+1] = mem[i];
    return f;
  endfunction

  function automatic frame_t rx_frame(input int k);
    frame_t f;
    for (int i = 0; i < 17; i++)
      f[i] = (k * 17 + i < rxq.size()) ? rxq[k*17+i] : 8'hxx;
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clr();
    rxq.delete(); stq.delete(); dq.delete();
    done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic wr(input int a, input logic [7:0] d, input bit taken);
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'(a); bus.i_wr_data = d;
    tick(1);
    bus.i_wr_en = 1'b0;
    if (taken) mem[a] = d;
  endtask

  task automatic start_pulse();
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (bus.o_done !== 1'b1 && t < 2 * FT) begin tick(1); t++; end
    n_cmp++;
    if (bus.o_done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_done_timeout: o_done=%b required 1", nm, bus.o_done);
    end
    tick(3);
  endtask

  task automatic wait_bytes(input int n, input string nm);
    int t = 0;
    while (rxq.size() < n && t < 2 * FT) begin tick(1); t++; end
    n_cmp++;
    if (rxq.size() < n) begin
      n_bad++;
      $display("FAIL %s_byte_timeout: got %0d bytes required %0d", nm, rxq.size(), n);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    RST = 1'b1;
    bus.i_start = 1'b1; bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd0; bus.i_wr_data = 8'hEE;
    tick(3);
    n_cmp++; if (bus.TX !== 1'b1)     begin n_bad++; $display("FAIL rst_tx: got %b required 1", bus.TX); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", bus.o_busy); end
    n_cmp++; if (bus.o_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b required 0", bus.o_done); end
    bus.i_start = 1'b0; bus.i_wr_en = 1'b0;
    RST = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (bus.TX !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL idle_1000: %0d bad cycles required 0", bad); end
  endtask

  // Also covers power-up zero buffer and the write/start ignored while RST was high.
  task automatic test_start_latency();
    clr();
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL lat_busy_n: got %b required 0", bus.o_busy); end
    tick(1);
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL lat_busy_n1: got %b required 1", bus.o_busy); end
    n_cmp++; if (bus.TX !== 1'b1)     begin n_bad++; $display("FAIL lat_tx_n1: got %b required 1", bus.TX); end
    tick(1);
    n_cmp++; if (bus.TX !== 1'b0)     begin n_bad++; $display("FAIL lat_tx_n2: got %b required 0", bus.TX); end
    wait_done("lat");
    n_cmp++; if (rx_frame(0) !== exp_frame()) begin n_bad++; $display("FAIL powerup_frame: got %h required %h", rx_frame(0), exp_frame()); end
  endtask

  task automatic test_frame_pattern();
    int gbad = 0;
    for (int i = 0; i < 16; i++) wr(i, 8'(i * 17), 1'b1);
    clr();
    start_pulse();
    wait_done("pat");
    n_cmp++; if (rx_frame(0) !== exp_frame()) begin n_bad++; $display("FAIL pat_frame: got %h required %h", rx_frame(0), exp_frame()); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL pat_done_cnt: got %0d required 1", done_cnt); end
    n_cmp++;
    if (busy_cnt < 17 * BYTE_T || busy_cnt > BUSY_MAX) begin
      n_bad++; $display("FAIL pat_busy_cycles: got %0d required %0d..%0d", busy_cnt, 17 * BYTE_T, BUSY_MAX);
    end
    if (stq.size() != 17) gbad = 99;
    else for (int i = 1; i < 17; i++)
      if (stq[i] - stq[i-1] < BYTE_T || stq[i] - stq[i-1] > BYTE_T + 2) gbad++;
    n_cmp++; if (gbad != 0) begin n_bad++; $display("FAIL pat_byte_gap: %0d bad gaps required 0", gbad); end
  endtask

  task automatic test_random_frame();
    int a;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) wr(i, 8'($urandom_range(255)), 1'b1);
    clr();
    a = $urandom_range(15);
    d = ~mem[a];
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'(a); bus.i_wr_data = d; bus.i_start = 1'b1;
    tick(1);
    bus.i_wr_en = 1'b0; bus.i_start = 1'b0;
    mem[a] = d;
    wait_done("rnd");
    n_cmp++; if (rx_frame(0) !== exp_frame()) begin n_bad++; $display("FAIL rnd_same_cycle_frame: got %h required %h", rx_frame(0), exp_frame()); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL rnd_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_write_during_busy();
    clr();
    start_pulse();
    tick(3 * BYTE_T);
    wr(3, 8'hAA, 1'b0);
    wr($urandom_range(15), 8'($urandom_range(255)), 1'b0);
    wait_done("wrb1");
    n_cmp++; if (rx_frame(0) !== exp_frame()) begin n_bad++; $display("FAIL wrbusy_snapshot: got %h required %h", rx_frame(0), exp_frame()); end
    wr(3, 8'hAA, 1'b1);
    clr();
    start_pulse();
    wait_done("wrb2");
    n_cmp++; if (rx_frame(0) !== exp_frame()) begin n_bad++; $display("FAIL wrbusy_next_frame: got %h required %h", rx_frame(0), exp_frame()); end
  endtask

  task automatic test_start_while_busy();
    clr();
    start_pulse();
    wait_bytes(5, "swb");
    tick(3 * CPB);
    start_pulse();
    wait_done("swb");
    tick(200);
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL swb_busy_after: got %b required 0", bus.o_busy); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL swb_done_cnt: got %0d required 1", done_cnt); end
    n_cmp++; if (rxq.size() != 17) begin n_bad++; $display("FAIL swb_bytes: got %0d required 17", rxq.size()); end
    n_cmp++; if (rx_frame(0) !== exp_frame()) begin n_bad++; $display("FAIL swb_frame: got %h required %h", rx_frame(0), exp_frame()); end
  endtask

  task automatic test_reset_mid_frame();
    clr();
    start_pulse();
    wait_bytes(8, "rmf");
    tick(4 * CPB);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    n_cmp++; if (bus.TX !== 1'b1)     begin n_bad++; $display("FAIL rmf_tx: got %b required 1", bus.TX); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL rmf_busy: got %b required 0", bus.o_busy); end
    tick(FT);
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL rmf_no_done: got %0d required 0", done_cnt); end
    n_cmp++; if (rxq.size() != 8) begin n_bad++; $display("FAIL rmf_partial: got %0d bytes required 8", rxq.size()); end
    clr();
    start_pulse();
    wait_done("rmf");
    n_cmp++; if (rx_frame(0) !== exp_frame()) begin n_bad++; $display("FAIL rmf_restart_frame: got %h required %h", rx_frame(0), exp_frame()); end
  endtask

  task automatic test_back_to_back();
    int t = 0;
    int nf;
    int lbad = 0;
    clr();
    bus.i_start = 1'b1;
    tick(3 * FT);
    bus.i_start = 1'b0;
    while (bus.o_busy === 1'b1 && t < 2 * FT) begin tick(1); t++; end
    tick(5);
    nf = done_cnt;
    n_cmp++; if (nf < 3) begin n_bad++; $display("FAIL b2b_frames: got %0d required >=3", nf); end
    n_cmp++; if (rxq.size() != 17 * nf) begin n_bad++; $display("FAIL b2b_bytes: got %0d required %0d", rxq.size(), 17 * nf); end
    for (int k = 0; k < nf; k++) begin
      n_cmp++;
      if (rx_frame(k) !== exp_frame()) begin
        n_bad++; $display("FAIL b2b_frame%0d: got %h required %h", k, rx_frame(k), exp_frame());
      end
    end
    // restart on first idle cycle: done seen, then header start bit 4 cycles later
    for (int k = 1; k < nf; k++)
      if (stq.size() <= 17 * k || dq.size() < k || stq[17*k] - dq[k-1] != 4) lbad++;
    n_cmp++; if (lbad != 0) begin n_bad++; $display("FAIL b2b_restart_latency: %0d bad restarts required 0", lbad); end
    n_cmp++; if (frame_err != 0) begin n_bad++; $display("FAIL framing: %0d start/stop errors required 0", frame_err); end
  endtask

  initial begin
    bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_start = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;
    tick(2);
    test_reset();
    test_start_latency();
    test_frame_pattern();
    test_random_frame();
    test_write_during_busy();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
